// File: rtl/ad9253_pkg.sv
// ad9253_pkg: shared widths, FSM state and test-pattern codes for the AD9253 serial emulator
package ad9253_pkg;
  localparam int DATA_W = 14;
  localparam int LANE_BITS = 8;
  localparam int FRAME_W = 2 * LANE_BITS;
  localparam int CNT_W = $clog2(LANE_BITS);
  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [1:0] {PAT_INPUT = 2'b00, PAT_MID = 2'b01, PAT_CHK = 2'b10, PAT_RAMP = 2'b11} pat_t;
  localparam logic [DATA_W-1:0] MIDSCALE = 14'h2000;
  localparam logic [DATA_W-1:0] CHK_A = 14'h2AAA;
  localparam logic [DATA_W-1:0] CHK_B = 14'h1555;
  function automatic logic [FRAME_W-1:0] frame_word(input logic [DATA_W-1:0] s);
    return {s, {(FRAME_W - DATA_W){1'b0}}};
  endfunction
endpackage

// File: rtl/ad9253_lane_ser.sv
// ad9253_lane_ser: loads one frame word and shifts it out MSB pair first onto the H/L lanes
module ad9253_lane_ser
  import ad9253_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               shift,
  input  logic [FRAME_W-1:0] word,
  output logic               h,
  output logic               l
);
  logic [FRAME_W-1:0] sr;
  logic [FRAME_W-1:0] src;
  assign src = load ? word : sr;
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
      h <= 1'b0;
      l <= 1'b0;
    end else begin
      sr <= {src[FRAME_W-3:0], 2'b00};
      h <= (load | shift) & src[FRAME_W-1];
      l <= (load | shift) & src[FRAME_W-2];
    end
  end
endmodule

// File: rtl/ad9253_serial_tx.sv
// ad9253_serial_tx: AD9253 two-lane LVDS transmit emulator; define AD9253_TEST_PATTERN_EN for pattern_sel test patterns
module ad9253_serial_tx
  import ad9253_pkg::*;
#(
  parameter int UNDERRUN_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_W-1:0]     s_ch0,
  input  logic [DATA_W-1:0]     s_ch1,
  input  logic [DATA_W-1:0]     s_ch2,
  input  logic [DATA_W-1:0]     s_ch3,
`ifdef AD9253_TEST_PATTERN_EN
  input  logic [1:0]            pattern_sel,
`endif
  output logic                  data_a_h,
  output logic                  data_a_l,
  output logic                  data_b_h,
  output logic                  data_b_l,
  output logic                  data_c_h,
  output logic                  data_c_l,
  output logic                  data_d_h,
  output logic                  data_d_l,
  output logic                  fco,
  output logic                  dco,
  output logic [UNDERRUN_W-1:0] underrun_cnt,
  output logic                  busy
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LANE_BITS - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(LANE_BITS / 2);
  state_t state;
  logic [CNT_W-1:0] bit_cnt, next_cnt;
  logic [3:0][DATA_W-1:0] ch, hold, src, sel;
  logic [3:0] h_bits, l_bits;
  logic hs, last, start, shift, next_idle;
  assign ch = {s_ch3, s_ch2, s_ch1, s_ch0};
  assign hs = s_ready & s_valid;
  assign last = state == RUN && bit_cnt == LAST;
  assign start = state == IDLE ? hs : last & s_ready;
  assign shift = state == RUN && !last;
  assign next_idle = !start && !shift;
  assign next_cnt = start ? '0 : bit_cnt + 1'b1;
  assign src = hs ? ch : hold;
`ifdef AD9253_TEST_PATTERN_EN
  logic [DATA_W-1:0] ramp, ramp_val, chk_val, pat;
  logic chk_b;
  assign ramp_val = state == IDLE ? '0 : ramp;
  assign chk_val = state == RUN && chk_b ? CHK_B : CHK_A;
  assign pat = pattern_sel == PAT_MID ? MIDSCALE : pattern_sel == PAT_CHK ? chk_val : ramp_val;
  assign sel = pattern_sel == PAT_INPUT ? src : {4{pat}};
  always_ff @(posedge clk) begin
    if (rst) begin
      ramp <= '0;
      chk_b <= 1'b0;
    end else if (start) begin
      ramp <= ramp_val + 1'b1;
      chk_b <= !(state == RUN && chk_b);
    end
  end
`else
  assign sel = src;
`endif
  for (genvar g = 0; g < 4; g++) begin : g_lane
    ad9253_lane_ser u_ser (
      .clk   (clk),
      .rst   (rst),
      .load  (start),
      .shift (shift),
      .word  (frame_word(sel[g])),
      .h     (h_bits[g]),
      .l     (l_bits[g])
    );
  end
  assign {data_d_h, data_c_h, data_b_h, data_a_h} = h_bits;
  assign {data_d_l, data_c_l, data_b_l, data_a_l} = l_bits;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bit_cnt <= '0;
      hold <= '0;
      fco <= 1'b0;
      dco <= 1'b0;
      busy <= 1'b0;
      s_ready <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      state <= next_idle ? IDLE : RUN;
      bit_cnt <= next_idle ? '0 : next_cnt;
      fco <= !next_idle && next_cnt < HALF;
      dco <= !next_idle && !dco;
      busy <= !next_idle;
      s_ready <= en && (next_idle || next_cnt == LAST);
      if (hs) hold <= ch;
      if (last && s_ready && !s_valid && !(&underrun_cnt)) underrun_cnt <= underrun_cnt + 1'b1;
    end
  end
endmodule

// File: doc/ad9253_serial_tx.md
Name: ad9253_serial_tx

Overview:
- Transmit-side emulator of the AD9253 two-lane serial LVDS output.
- Serializes four 14-bit channel samples into the eight lane bits (Data_x_H/Data_x_L), plus frame clock (FCO) and data clock (DCO).
- Drives the receiver path on-board for loopback and bring-up without the ADC fitted.
- Runs in the fast PLL domain, one serial bit per clk per lane.

Parameters:
- DATA_W, 14, sample width per channel.
- LANE_BITS, 8, bits per lane per frame. Frame word = {sample, (2*LANE_BITS-DATA_W) zeros}, MSB first.
- UNDERRUN_W, 16, width of the saturating underrun counter.

Ports:
- clk  in  1  bit clock; one serial bit per cycle.
- rst  in  1  synchronous reset, active-high.
- en  in  1  run request.
- s_valid  in  1  sample set valid.
- s_ready  out  1  sample set accepted when s_valid&s_ready.
- s_ch0..s_ch3  in  DATA_W each  channel samples.
- data_a_h, data_a_l .. data_d_h, data_d_l  out  1 each  lane outputs; H = odd frame bits, L = even frame bits.
- fco  out  1  frame clock.
- dco  out  1  bit clock out.
- underrun_cnt  out  UNDERRUN_W  frames sent with repeated data.
- busy  out  1  high in RUN.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- All outputs are registered.
- Reset: state=IDLE. Lanes, fco, dco, busy, s_ready, underrun_cnt all 0. Held samples cleared to 0.
- IDLE:
  - s_ready = en.
  - On handshake: load the four samples, bit_cnt=0, go to RUN.
  - Latency: handshake at cycle t gives the first bit on the lanes at t+1 with fco=1.
- RUN, bit_cnt 0..LANE_BITS-1:
  - Lane H outputs frame bit 2*(LANE_BITS-1-bit_cnt)+1.
  - Lane L outputs frame bit 2*(LANE_BITS-1-bit_cnt).
  - fco = 1 for bit_cnt < LANE_BITS/2, else 0.
  - dco toggles every cycle; it is edge-aligned with data, and the receiver phase-shifts.
  - busy = 1.
- Frame boundary (cycle where bit_cnt==LANE_BITS-1), s_ready = en:
  - en & s_valid: new samples are serialized next cycle, seamless, with no gap.
  - en & !s_valid: last samples are repeated; underrun_cnt += 1, saturating at all-ones.
  - !en: frame completes, then IDLE with outputs low and dco held 0.
- en deasserted mid-frame: the current frame always completes; there are no partial frames.
- s_ready is 0 at all non-boundary RUN cycles. s_valid held without ready is ignored.
- rst mid-frame: immediate return to reset values on the next edge.
- bit_cnt wraps LANE_BITS-1 -> 0.

Optional Feature:
- Macro: AD9253_TEST_PATTERN_EN.
- When defined, adds input pattern_sel[1:0], sampled at each frame boundary. The selected value replaces all channels:
  - 00: input samples.
  - 01: midscale 0x2000.
  - 10: checkerboard alternating 0x2AAA / 0x1555 per frame, starting 0x2AAA.
  - 11: ramp, +1 per frame, wrapping 0x3FFF->0, starting 0 on entry to RUN.
- In pattern modes the handshake and underrun logic are unchanged.
- When undefined: the port is absent and data always comes from s_ch*.

Decomposition:
- Package ad9253_pkg holds:
  - DATA_W, LANE_BITS.
  - State enum {IDLE, RUN}.
  - Pattern codes and constants MIDSCALE=0x2000, CHK_A=0x2AAA, CHK_B=0x1555.
- Sub-module ad9253_lane_ser, instantiated 4x.
  - Function: per-channel load/shift of the 2*LANE_BITS frame word onto the H/L lanes.
  - Control: load and shift strobes come from the top-level FSM.

Test Plan:
- Single frame, s_ch0=0x3A5C, en=1:
  - data_a_h = 1,1,1,0,0,1,0,0.
  - data_a_l = 1,0,0,1,1,1,0,0.
  - fco = 1,1,1,1,0,0,0,0.
  - dco toggles 8 times.
- Back-to-back: 4 sample sets each offered on its boundary. Result: 32 contiguous bits, fco period 8, no idle cycle, underrun_cnt=0.
- Underrun: s_valid low at 3 consecutive boundaries. Result: last sample repeated 3 frames, underrun_cnt=3. Preloaded 0xFFFF saturates (stays 0xFFFF).
- en dropped at bit_cnt=2: frame finishes at bit 7, then IDLE. Lanes/fco/dco/busy are 0 next cycle; s_ready=0.
- rst asserted at bit_cnt=5: all outputs 0 the next cycle. Restart gives first bit 1 cycle after the handshake.
- With AD9253_TEST_PATTERN_EN:
  - pattern_sel=10: frames carry 0x2AAA, 0x1555, 0x2AAA.
  - pattern_sel=11: successive frames carry 0, 1, 2.
  - Wrap check: ramp seeded at 0x3FFF gives 0 next.
